// File: rtl/synth_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : synth_cfg_pkg
// Description : Shared constants, state encoding and CRC-8 helper for the
//               synth configuration receiver (synth_cfg_rx / synth_cfg_chk).
// Revision    : 1.0 - initial release
// ============================================================================
package synth_cfg_pkg;

  // Section identifiers carried in the frame ID byte
  localparam logic [7:0] SEC_GLOBAL   = 8'h00;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

  // Payload sizes in 32-bit words
  localparam int GLOB_WORDS = 6;

  function automatic int OSC_WORDS(input int env_len);
    return 3 + 2 * env_len;
  endfunction

  // Receiver state encoding
  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ID      = 3'd1,
    PAYLOAD = 3'd2,
    CHECK   = 3'd3,
    COMMIT  = 3'd4
  } state_e;

  // Oscillator waveform encoding, mirrors the oscillator shape field
  typedef enum logic [1:0] {
    SHAPE_SQUARE = 2'd0,
    SHAPE_SAW    = 2'd1,
    SHAPE_SIN    = 2'd2,
    SHAPE_TRI    = 2'd3
  } shape_e;

  // One byte of CRC-8, poly 0x07, MSB-first, no reflection
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synth_cfg_chk.sv
`default_nettype none
// ============================================================================
// Module      : synth_cfg_chk
// Description : Byte-wise frame integrity accumulator with clear and enable.
//               SYNTH_CFG_CRC8_EN defined   -> CRC-8 (poly 0x07, init 0x00)
//               SYNTH_CFG_CRC8_EN undefined -> XOR of all bytes
//               Clear and enable together start a new sum seeded by data_i.
// Revision    : 1.0 - initial release
// ============================================================================
module synth_cfg_chk
  import synth_cfg_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic [7:0] data_i,
  output logic [7:0] acc_o
);

  logic [7:0] acc_q;
  logic [7:0] acc_d;
  logic [7:0] base;
  logic [7:0] step;

  // Next accumulator: optionally restart from zero, then fold in the byte
  always_comb begin
    base = clr_i ? 8'h00 : acc_q;
`ifdef SYNTH_CFG_CRC8_EN
    step = crc8_step(base, data_i);
`else
    step = base ^ data_i;
`endif
    acc_d = en_i ? step : base;
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) acc_q <= 8'h00;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule
`default_nettype wire

// File: rtl/synth_cfg_rx.sv
`default_nettype none
// ============================================================================
// Module      : synth_cfg_rx
// Description : Framed byte-stream configuration receiver. Frames are
//               SYNC, ID, payload, CHK. ID 0 carries the 6 global words,
//               ID k carries oscillator k-1. Payload lands in a shadow
//               buffer and is copied to the live slot only after the
//               integrity byte matches. SYNTH_CFG_CRC8_EN selects CRC-8
//               instead of XOR for the integrity byte.
//               Output packing: the first word of a section occupies the
//               most significant 32 bits of that section's vector; the
//               oscillator k record sits at osc_cfg_o[k*OSC_W +: OSC_W].
// Revision    : 1.0 - initial release
// ============================================================================
module synth_cfg_rx
  import synth_cfg_pkg::*;
#(
  parameter int         N_OSC       = 16,
  parameter int         ENV_LEN     = 8,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = SYNC_DEFAULT,
  localparam int        OSC_W       = 32 * OSC_WORDS(ENV_LEN)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [7:0]             rx_data_i,
  input  logic                   rx_valid_i,
  output logic                   rx_ready_o,
  output logic [6*32-1:0]        glob_cfg_o,
  output logic [N_OSC*OSC_W-1:0] osc_cfg_o,
  output logic [N_OSC-1:0]       osc_upd_o,
  output logic                   glob_upd_o,
  output logic                   frame_err_o,
  output logic                   busy_o
);

  localparam int c_OSC_WORDS = OSC_WORDS(ENV_LEN);
  localparam int c_MAX_WORDS = (c_OSC_WORDS > GLOB_WORDS) ? c_OSC_WORDS : GLOB_WORDS;
  localparam int c_BCNT_W    = $clog2(4 * c_MAX_WORDS);
  localparam int c_WIDX_W    = c_BCNT_W - 2;
  localparam int c_IDLE_W    = $clog2(TIMEOUT_CYC + 1);

  state_e                state_q, state_d;
  logic [7:0]            id_q, id_d;
  logic [c_BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic [c_IDLE_W-1:0]   idle_q, idle_d;
  logic                  err_q, err_d;
  logic [23:0]           word_q;
  logic [31:0]           shadow_q [c_MAX_WORDS];
  logic [31:0]           glob_q   [GLOB_WORDS];
  logic                  glob_upd_q;

  logic                  accept;
  logic                  timeout;
  logic                  commit;
  logic                  shadow_we;
  logic                  chk_clr;
  logic                  chk_en;
  logic [7:0]            chk_acc;
  logic [c_BCNT_W-1:0]   last_byte;
  logic [c_WIDX_W-1:0]   widx;

  assign rx_ready_o = (state_q != COMMIT);
  assign busy_o     = (state_q != HUNT);
  assign accept     = rx_valid_i && rx_ready_o;
  assign commit     = (state_q == COMMIT);
  assign last_byte  = (id_q == SEC_GLOBAL) ? c_BCNT_W'(4 * GLOB_WORDS - 1)
                                           : c_BCNT_W'(4 * c_OSC_WORDS - 1);
  assign widx       = bcnt_q[c_BCNT_W-1:2];

  synth_cfg_chk u_chk (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (chk_clr),
    .en_i   (chk_en),
    .data_i (rx_data_i),
    .acc_o  (chk_acc)
  );

  // Frame parser: next state, counters, checksum control and error pulse
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    bcnt_d    = bcnt_q;
    err_d     = 1'b0;
    chk_clr   = 1'b0;
    chk_en    = 1'b0;
    shadow_we = 1'b0;
    timeout   = 1'b0;

    // Idle time only matters inside a frame; any accepted byte restarts it
    if (accept || state_q == HUNT || state_q == COMMIT) idle_d = '0;
    else                                                 idle_d = idle_q + 1'b1;

    case (state_q)
      HUNT: begin
        if (accept && rx_data_i == SYNC_BYTE) state_d = ID;
      end
      ID: begin
        if (accept) begin
          id_d = rx_data_i;
          if (rx_data_i <= 8'(N_OSC)) begin
            state_d = PAYLOAD;
            bcnt_d  = '0;
            chk_clr = 1'b1;
            chk_en  = 1'b1;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          chk_en    = 1'b1;
          shadow_we = 1'b1;
          if (bcnt_q == last_byte) begin
            state_d = CHECK;
            bcnt_d  = '0;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
          end
        end
      end
      CHECK: begin
        if (accept) begin
          if (rx_data_i == chk_acc) begin
            state_d = COMMIT;
          end else begin
            state_d = HUNT;
            err_d   = 1'b1;
          end
        end
      end
      COMMIT: state_d = HUNT;
      default: state_d = HUNT;
    endcase

    // Stalled source inside a frame abandons it
    if ((state_q == ID || state_q == PAYLOAD || state_q == CHECK) && !accept &&
        idle_q == c_IDLE_W'(TIMEOUT_CYC - 1)) begin
      timeout = 1'b1;
      state_d = HUNT;
      err_d   = 1'b1;
      idle_d  = '0;
    end
  end

  // Parser state and counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= HUNT;
      id_q    <= 8'h00;
      bcnt_q  <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      bcnt_q  <= bcnt_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
    end
  end

  // Shadow buffer: bytes assemble big-endian, every 4th byte writes a word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= 24'h0;
      for (int w = 0; w < c_MAX_WORDS; w++) shadow_q[w] <= 32'h0;
    end else if (shadow_we) begin
      if (bcnt_q[1:0] == 2'd3) shadow_q[widx] <= {word_q, rx_data_i};
      else                     word_q         <= {word_q[15:0], rx_data_i};
    end
  end

  // Live global words and their update strobe
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      glob_upd_q <= 1'b0;
      for (int w = 0; w < GLOB_WORDS; w++) glob_q[w] <= 32'h0;
    end else begin
      glob_upd_q <= commit && (id_q == SEC_GLOBAL);
      if (commit && id_q == SEC_GLOBAL) begin
        for (int w = 0; w < GLOB_WORDS; w++) glob_q[w] <= shadow_q[w];
      end
    end
  end

  generate
    for (genvar w = 0; w < GLOB_WORDS; w++) begin : g_glob_map
      assign glob_cfg_o[(GLOB_WORDS-1-w)*32 +: 32] = glob_q[w];
    end

    for (genvar o = 0; o < N_OSC; o++) begin : g_osc
      logic [31:0] rec_q [c_OSC_WORDS];
      logic        upd_q;
      logic        sel;

      assign sel = commit && (id_q == 8'(o + 1));

      // Live oscillator record; shape resets to SIN
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          upd_q <= 1'b0;
          for (int w = 0; w < c_OSC_WORDS - 1; w++) rec_q[w] <= 32'h0;
          rec_q[c_OSC_WORDS-1] <= {30'h0, SHAPE_SIN};
        end else begin
          upd_q <= sel;
          if (sel) begin
            for (int w = 0; w < c_OSC_WORDS; w++) rec_q[w] <= shadow_q[w];
          end
        end
      end

      assign osc_upd_o[o] = upd_q;

      for (genvar w = 0; w < c_OSC_WORDS; w++) begin : g_word
        assign osc_cfg_o[o*OSC_W + (c_OSC_WORDS-1-w)*32 +: 32] = rec_q[w];
      end
    end
  endgenerate

  assign glob_upd_o  = glob_upd_q;
  assign frame_err_o = err_q;

endmodule
`default_nettype wire

// File: tb/tb_synth_cfg_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_synth_cfg_rx
// Description : Directed self-checking bench for synth_cfg_rx. The expected
//               integrity byte follows SYNTH_CFG_CRC8_EN like the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_synth_cfg_rx;

  localparam int         N_OSC       = 4;
  localparam int         ENV_LEN     = 8;
  localparam int         TIMEOUT_CYC = 64;
  localparam logic [7:0] SYNC        = 8'hA5;
  localparam int         OSC_WORDS   = 3 + 2 * ENV_LEN;
  localparam int         OSC_W       = 32 * OSC_WORDS;

  typedef logic [OSC_W-1:0] vec_t;

  logic                   clk = 1'b0;
  logic                   rstn = 1'b0;
  logic [7:0]             rx_data = 8'h00;
  logic                   rx_valid = 1'b0;
  logic                   rx_ready_o;
  logic [6*32-1:0]        glob_cfg_o;
  logic [N_OSC*OSC_W-1:0] osc_cfg_o;
  logic [N_OSC-1:0]       osc_upd_o;
  logic                   glob_upd_o;
  logic                   frame_err_o;
  logic                   busy_o;

  int checks = 0;
  int errors = 0;
  int stalls = 0;

  logic [7:0]   pl [$];
  logic [191:0] exp_glob;
  vec_t         exp_rec [N_OSC];

  synth_cfg_rx #(
    .N_OSC       (N_OSC),
    .ENV_LEN     (ENV_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_BYTE   (SYNC)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .rx_data_i   (rx_data),
    .rx_valid_i  (rx_valid),
    .rx_ready_o  (rx_ready_o),
    .glob_cfg_o  (glob_cfg_o),
    .osc_cfg_o   (osc_cfg_o),
    .osc_upd_o   (osc_upd_o),
    .glob_upd_o  (glob_upd_o),
    .frame_err_o (frame_err_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input vec_t obs, input vec_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_live(input string tag);
    check({tag, "_glob"}, vec_t'(glob_cfg_o), vec_t'(exp_glob));
    for (int o = 0; o < N_OSC; o++)
      check($sformatf("%s_osc%0d", tag, o), osc_cfg_o[o*OSC_W +: OSC_W], exp_rec[o]);
  endtask

  task automatic reset_model();
    exp_glob = '0;
    for (int o = 0; o < N_OSC; o++) exp_rec[o] = vec_t'(2);
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] id);
    logic [7:0] c;
    logic [7:0] bytes [$];
    bytes = {id};
    foreach (pl[i]) bytes.push_back(pl[i]);
    c = 8'h00;
    foreach (bytes[i]) begin
`ifdef SYNTH_CFG_CRC8_EN
      c = c ^ bytes[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
`else
      c = c ^ bytes[i];
`endif
    end
    return c;
  endfunction

  task automatic push_word(input logic [31:0] w);
    pl.push_back(w[31:24]);
    pl.push_back(w[23:16]);
    pl.push_back(w[15:8]);
    pl.push_back(w[7:0]);
  endtask

  task automatic build_glob(input logic [31:0] vol);
    pl.delete();
    push_word(vol);
    repeat (5) push_word(32'h0);
  endtask

  task automatic build_osc(input logic [31:0] freq);
    pl.delete();
    push_word(freq);
    repeat (OSC_WORDS - 1) push_word(32'h0);
  endtask

  // Present one byte from a negedge and return just after the accepting edge
  task automatic send(input logic [7:0] b);
    int guard;
    guard = 0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready_o !== 1'b1 && guard < 8) begin
      stalls++;
      guard++;
      @(negedge clk);
    end
    checks++;
    assert (guard < 8) else begin
      errors++;
      $error("FAIL ready_stuck: observed %0d low cycles expected under 8", guard);
    end
    @(posedge clk);
  endtask

  task automatic send_frame(input logic [7:0] id, input logic [7:0] mask);
    send(SYNC);
    send(id);
    foreach (pl[i]) send(pl[i]);
    send(calc_chk(id) ^ mask);
  endtask

  task automatic commit_obs(input string tag, input logic exp_g, input logic [N_OSC-1:0] exp_o);
    @(negedge clk);
    rx_valid = 1'b0;
    check({tag, "_commit_ready"}, vec_t'(rx_ready_o), vec_t'(0));
    check({tag, "_commit_busy"}, vec_t'(busy_o), vec_t'(1));
    check({tag, "_early_upd"}, vec_t'({glob_upd_o, osc_upd_o}), vec_t'(0));
    @(negedge clk);
    check({tag, "_glob_upd"}, vec_t'(glob_upd_o), vec_t'(exp_g));
    check({tag, "_osc_upd"}, vec_t'(osc_upd_o), vec_t'(exp_o));
    check({tag, "_err"}, vec_t'(frame_err_o), vec_t'(0));
    check({tag, "_ready"}, vec_t'(rx_ready_o), vec_t'(1));
    check_live(tag);
    @(negedge clk);
    check({tag, "_upd_clear"}, vec_t'({glob_upd_o, osc_upd_o}), vec_t'(0));
  endtask

  task automatic err_obs(input string tag);
    @(negedge clk);
    rx_valid = 1'b0;
    check({tag, "_err"}, vec_t'(frame_err_o), vec_t'(1));
    check({tag, "_busy"}, vec_t'(busy_o), vec_t'(0));
    check({tag, "_upd"}, vec_t'({glob_upd_o, osc_upd_o}), vec_t'(0));
    @(negedge clk);
    check({tag, "_err_clear"}, vec_t'(frame_err_o), vec_t'(0));
    check({tag, "_upd_none"}, vec_t'({glob_upd_o, osc_upd_o}), vec_t'(0));
    check_live(tag);
  endtask

  initial begin
    reset_model();

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ready", vec_t'(rx_ready_o), vec_t'(1));
    check("rst_busy", vec_t'(busy_o), vec_t'(0));
    check("rst_pulses", vec_t'({glob_upd_o, osc_upd_o, frame_err_o}), vec_t'(0));
    check_live("rst");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Global frame, volume 0x100
    build_glob(32'h0000_0100);
    send(SYNC);
    send(8'h00);
    check("glob_busy", vec_t'(busy_o), vec_t'(1));
    foreach (pl[i]) send(pl[i]);
    send(calc_chk(8'h00));
    exp_glob = {32'h0000_0100, 160'h0};
    commit_obs("glob1", 1'b1, 4'b0000);

    // Oscillator 2 (ID 3), freq 0x1B8
    build_osc(32'h0000_01B8);
    send_frame(8'h03, 8'h00);
    exp_rec[2] = vec_t'(32'h0000_01B8) << ((OSC_WORDS - 1) * 32);
    commit_obs("osc2", 1'b0, 4'b0100);

    // Corrupted integrity byte leaves live state alone
    build_osc(32'h0000_2222);
    send_frame(8'h03, 8'h01);
    err_obs("badchk");

    // Out-of-range ID, then a normal frame
    send(SYNC);
    send(8'(N_OSC + 1));
    err_obs("badid");
    build_glob(32'h1234_5678);
    send_frame(8'h00, 8'h00);
    exp_glob = {32'h1234_5678, 160'h0};
    commit_obs("glob2", 1'b1, 4'b0000);

    // Stall after 10 payload bytes
    build_osc(32'h0000_9999);
    send(SYNC);
    send(8'h01);
    for (int i = 0; i < 10; i++) send(pl[i]);
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (TIMEOUT_CYC - 1) @(negedge clk);
    check("to_edge_busy", vec_t'(busy_o), vec_t'(1));
    check("to_edge_err", vec_t'(frame_err_o), vec_t'(0));
    @(negedge clk);
    check("to_err", vec_t'(frame_err_o), vec_t'(1));
    check("to_busy", vec_t'(busy_o), vec_t'(0));
    @(negedge clk);
    check("to_err_clear", vec_t'(frame_err_o), vec_t'(0));
    check_live("to");
    build_osc(32'h0000_ABCD);
    send_frame(8'h02, 8'h00);
    exp_rec[1] = vec_t'(32'h0000_ABCD) << ((OSC_WORDS - 1) * 32);
    commit_obs("osc1", 1'b0, 4'b0010);

    // Reset in the middle of a payload
    build_osc(32'h1111_1111);
    send(SYNC);
    send(8'h04);
    for (int i = 0; i < 8; i++) send(pl[i]);
    @(negedge clk);
    rx_valid = 1'b0;
    rstn     = 1'b0;
    #1;
    reset_model();
    check("mid_rst_ready", vec_t'(rx_ready_o), vec_t'(1));
    check("mid_rst_busy", vec_t'(busy_o), vec_t'(0));
    check_live("mid_rst");
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // Back-to-back frames with valid held high across COMMIT
    stalls = 0;
    build_glob(32'hCAFE_F00D);
    send_frame(8'h00, 8'h00);
    check("b2b_no_stall_first", vec_t'(stalls), vec_t'(0));
    build_osc(32'h0000_1234);
    send_frame(8'h04, 8'h00);
    check("b2b_one_stall", vec_t'(stalls), vec_t'(1));
    exp_glob = {32'hCAFE_F00D, 160'h0};
    exp_rec[3] = vec_t'(32'h0000_1234) << ((OSC_WORDS - 1) * 32);
    commit_obs("b2b", 1'b0, 4'b1000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
